// File: rtl/esfa_pkg.sv
`default_nettype none
// ============================================================================
// esfa_pkg : shared selector opcodes, reducer state encoding, field width
// Rev 1.0
// ============================================================================
package esfa_pkg;

   localparam int DATA_W_DEF = 8;

   localparam logic [7:0] SEL_UPDATE       = 8'd0;
   localparam logic [7:0] SEL_LOOKUP       = 8'd1;
   localparam logic [7:0] SEL_ENCODE       = 8'd2;
   localparam logic [7:0] SEL_CONGRUE_UP   = 8'd3;
   localparam logic [7:0] SEL_CONGRUE_DOWN = 8'd4;
   localparam logic [7:0] SEL_MARK_AVAIL   = 8'd5;
   localparam logic [7:0] SEL_ENRANK       = 8'd6;
   localparam logic [7:0] SEL_DEBUG        = 8'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } reducer_state_e;

   // Only lookUpScan picks the highest-ranked hit; every other opcode
   // (including undefined ones) keeps the first hit.
   function automatic logic is_rank_select(input logic [7:0] sel);
      return (sel == SEL_LOOKUP);
   endfunction

endpackage
`default_nettype wire

// File: rtl/cell_select_step.sv
`default_nettype none
// ============================================================================
// cell_select_step : one scan step - win rule and hit-count update
// Rev 1.0
// ============================================================================
module cell_select_step
   import esfa_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic [7:0]        sel_i,
   input  logic [7:0]        idx_i,
   input  logic              best_found_i,
   input  logic [7:0]        best_idx_i,
   input  logic [DATA_W-1:0] best_value_i,
   input  logic [DATA_W-1:0] best_context_i,
   input  logic [7:0]        hits_i,
   input  logic              cell_bool_i,
   input  logic [DATA_W-1:0] cell_value_i,
   input  logic [DATA_W-1:0] cell_context_i,
   output logic              next_found_o,
   output logic [7:0]        next_idx_o,
   output logic [DATA_W-1:0] next_value_o,
   output logic [DATA_W-1:0] next_context_o,
   output logic [7:0]        next_hits_o
);

   logic take;

   // Strict compare keeps the earlier (lower-index) cell on a rank tie.
   assign take = cell_bool_i &&
                 (!best_found_i ||
                  (is_rank_select(sel_i) && (cell_context_i > best_context_i)));

   assign next_found_o   = best_found_i | cell_bool_i;
   assign next_idx_o     = take ? idx_i          : best_idx_i;
   assign next_value_o   = take ? cell_value_i   : best_value_i;
   assign next_context_o = take ? cell_context_i : best_context_i;
   assign next_hits_o    = hits_i + {7'd0, cell_bool_i};

endmodule
`default_nettype wire

// File: rtl/cell_result_reducer.sv
`default_nettype none
// ============================================================================
// cell_result_reducer : sequential scan of all cell outputs to one answer
// Rev 1.0
// ============================================================================
module cell_result_reducer
   import esfa_pkg::*;
#(
   parameter int N_CELLS = 8,
   parameter int DATA_W  = DATA_W_DEF
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [7:0]                selector,
   input  logic [N_CELLS-1:0]        bool_vec,
   input  logic [N_CELLS*DATA_W-1:0] value_bus,
   input  logic [N_CELLS*DATA_W-1:0] context_bus,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic                      out_found,
   output logic [DATA_W-1:0]         out_value,
   output logic [DATA_W-1:0]         out_context,
   output logic [7:0]                out_index,
   output logic [7:0]                out_hits,
   output logic                      busy
);

   localparam logic [7:0] LAST_IDX = 8'(N_CELLS - 1);

   reducer_state_e            state_q, state_d;
   logic [7:0]                sel_q, sel_d;
   logic [N_CELLS-1:0]        bool_q, bool_d;
   logic [N_CELLS*DATA_W-1:0] value_q, value_d;
   logic [N_CELLS*DATA_W-1:0] context_q, context_d;
   logic [7:0]                idx_q, idx_d;
   logic                      found_q, found_d;
   logic [7:0]                best_idx_q, best_idx_d;
   logic [DATA_W-1:0]         best_value_q, best_value_d;
   logic [DATA_W-1:0]         best_context_q, best_context_d;
   logic [7:0]                hits_q, hits_d;
   logic                      out_valid_q, out_valid_d;
   logic                      out_found_q, out_found_d;
   logic [DATA_W-1:0]         out_value_q, out_value_d;
   logic [DATA_W-1:0]         out_context_q, out_context_d;
   logic [7:0]                out_index_q, out_index_d;
   logic [7:0]                out_hits_q, out_hits_d;

   logic                      cell_bool;
   logic [DATA_W-1:0]         cell_value;
   logic [DATA_W-1:0]         cell_context;
   logic                      step_found;
   logic [7:0]                step_idx;
   logic [DATA_W-1:0]         step_value;
   logic [DATA_W-1:0]         step_context;
   logic [7:0]                step_hits;

   assign in_ready    = (state_q == ST_IDLE) && reset;
   assign busy        = (state_q != ST_IDLE);
   assign out_valid   = out_valid_q;
   assign out_found   = out_found_q;
   assign out_value   = out_value_q;
   assign out_context = out_context_q;
   assign out_index   = out_index_q;
   assign out_hits    = out_hits_q;

   // Cell mux written as a compare loop so the 8-bit index needs no resize.
   always_comb begin
      cell_bool    = 1'b0;
      cell_value   = '0;
      cell_context = '0;
      for (int i = 0; i < N_CELLS; i++) begin
         if (idx_q == 8'(i)) begin
            cell_bool    = bool_q[i];
            cell_value   = value_q[i*DATA_W +: DATA_W];
            cell_context = context_q[i*DATA_W +: DATA_W];
         end
      end
   end

   cell_select_step #(
      .DATA_W (DATA_W)
   ) u_step (
      .sel_i          (sel_q),
      .idx_i          (idx_q),
      .best_found_i   (found_q),
      .best_idx_i     (best_idx_q),
      .best_value_i   (best_value_q),
      .best_context_i (best_context_q),
      .hits_i         (hits_q),
      .cell_bool_i    (cell_bool),
      .cell_value_i   (cell_value),
      .cell_context_i (cell_context),
      .next_found_o   (step_found),
      .next_idx_o     (step_idx),
      .next_value_o   (step_value),
      .next_context_o (step_context),
      .next_hits_o    (step_hits)
   );

   always_comb begin
      state_d        = state_q;
      sel_d          = sel_q;
      bool_d         = bool_q;
      value_d        = value_q;
      context_d      = context_q;
      idx_d          = idx_q;
      found_d        = found_q;
      best_idx_d     = best_idx_q;
      best_value_d   = best_value_q;
      best_context_d = best_context_q;
      hits_d         = hits_q;
      out_valid_d    = out_valid_q;
      out_found_d    = out_found_q;
      out_value_d    = out_value_q;
      out_context_d  = out_context_q;
      out_index_d    = out_index_q;
      out_hits_d     = out_hits_q;

      unique case (state_q)
         ST_IDLE: begin
            if (in_valid && in_ready) begin
               state_d        = ST_SCAN;
               sel_d          = selector;
               bool_d         = bool_vec;
               value_d        = value_bus;
               context_d      = context_bus;
               idx_d          = 8'd0;
               found_d        = 1'b0;
               best_idx_d     = 8'd0;
               best_value_d   = '0;
               best_context_d = '0;
               hits_d         = 8'd0;
            end
         end
         ST_SCAN: begin
            idx_d          = idx_q + 8'd1;
            found_d        = step_found;
            best_idx_d     = step_idx;
            best_value_d   = step_value;
            best_context_d = step_context;
            hits_d         = step_hits;
            // Publish straight from the step outputs so the last cell counts.
            if (idx_q == LAST_IDX) begin
               state_d       = ST_DONE;
               out_valid_d   = 1'b1;
               out_found_d   = step_found;
               out_value_d   = step_value;
               out_context_d = step_context;
               out_index_d   = step_idx;
               out_hits_d    = step_hits;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d     = ST_IDLE;
               out_valid_d = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q        <= ST_IDLE;
         sel_q          <= 8'd0;
         bool_q         <= '0;
         value_q        <= '0;
         context_q      <= '0;
         idx_q          <= 8'd0;
         found_q        <= 1'b0;
         best_idx_q     <= 8'd0;
         best_value_q   <= '0;
         best_context_q <= '0;
         hits_q         <= 8'd0;
         out_valid_q    <= 1'b0;
         out_found_q    <= 1'b0;
         out_value_q    <= '0;
         out_context_q  <= '0;
         out_index_q    <= 8'd0;
         out_hits_q     <= 8'd0;
      end else begin
         state_q        <= state_d;
         sel_q          <= sel_d;
         bool_q         <= bool_d;
         value_q        <= value_d;
         context_q      <= context_d;
         idx_q          <= idx_d;
         found_q        <= found_d;
         best_idx_q     <= best_idx_d;
         best_value_q   <= best_value_d;
         best_context_q <= best_context_d;
         hits_q         <= hits_d;
         out_valid_q    <= out_valid_d;
         out_found_q    <= out_found_d;
         out_value_q    <= out_value_d;
         out_context_q  <= out_context_d;
         out_index_q    <= out_index_d;
         out_hits_q     <= out_hits_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cell_result_reducer.sv
`default_nettype none
// ============================================================================
// tb_cell_result_reducer : randomized bench with transaction-level model
// Rev 1.0
// ============================================================================
module tb_cell_result_reducer;

   localparam int N  = 8;
   localparam int DW = 8;

   typedef struct packed {
      logic          found;
      logic [DW-1:0] value;
      logic [DW-1:0] ctx;
      logic [7:0]    index;
      logic [7:0]    hits;
   } res_t;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [7:0]      selector = 8'd0;
   logic [N-1:0]    bool_vec = '0;
   logic [N*DW-1:0] value_bus = '0;
   logic [N*DW-1:0] context_bus = '0;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic            out_found;
   logic [DW-1:0]   out_value;
   logic [DW-1:0]   out_context;
   logic [7:0]      out_index;
   logic [7:0]      out_hits;
   logic            busy;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   cell_result_reducer #(.N_CELLS(N), .DATA_W(DW)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .selector    (selector),
      .bool_vec    (bool_vec),
      .value_bus   (value_bus),
      .context_bus (context_bus),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_found   (out_found),
      .out_value   (out_value),
      .out_context (out_context),
      .out_index   (out_index),
      .out_hits    (out_hits),
      .busy        (busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic chk_res(input string name, input res_t got, input res_t exp);
      chk({name, ".found"}, 32'(got.found), 32'(exp.found));
      chk({name, ".value"}, 32'(got.value), 32'(exp.value));
      chk({name, ".ctx"},   32'(got.ctx),   32'(exp.ctx));
      chk({name, ".index"}, 32'(got.index), 32'(exp.index));
      chk({name, ".hits"},  32'(got.hits),  32'(exp.hits));
   endtask

   // Rank rule: take the maximum context among hits, then the lowest index
   // holding it. Other opcodes: lowest-index hit.
   function automatic res_t ref_reduce(input logic [7:0] s, input logic [N-1:0] b,
                                       input logic [N*DW-1:0] v, input logic [N*DW-1:0] c);
      res_t r;
      int   win;
      int   maxc;
      r    = '0;
      win  = -1;
      maxc = -1;
      r.hits = 8'($countones(b));
      if (s == 8'd1)
         for (int i = 0; i < N; i++)
            if (b[i] && int'(c[i*DW +: DW]) > maxc) maxc = int'(c[i*DW +: DW]);
      for (int i = N - 1; i >= 0; i--)
         if (b[i] && (s != 8'd1 || int'(c[i*DW +: DW]) == maxc)) win = i;
      if (win >= 0) begin
         r.found = 1'b1;
         r.value = v[win*DW +: DW];
         r.ctx   = c[win*DW +: DW];
         r.index = 8'(win);
      end
      return r;
   endfunction

   // Timing model: idle -> N scan edges -> done until out_ready.
   int   m_phase = 0;
   int   m_cnt   = 0;
   res_t m_pend  = '0;
   res_t m_out   = '0;
   logic m_ov    = 1'b0;

   always @(posedge clk) begin
      if (!reset) begin
         m_phase = 0;
         m_ov    = 1'b0;
         m_out   = '0;
      end else begin
         case (m_phase)
            0: if (in_valid) begin
                  m_phase = 1;
                  m_cnt   = 0;
                  m_pend  = ref_reduce(selector, bool_vec, value_bus, context_bus);
               end
            1: begin
                  m_cnt++;
                  if (m_cnt == N) begin
                     m_phase = 2;
                     m_ov    = 1'b1;
                     m_out   = m_pend;
                  end
               end
            default: if (out_ready) begin
                  m_phase = 0;
                  m_ov    = 1'b0;
               end
         endcase
      end
   end

   always @(posedge clk) begin
      #1;
      chk("in_ready", 32'(in_ready), 32'((m_phase == 0) && reset));
      chk("busy", 32'(busy), 32'(m_phase != 0));
      chk("out_valid", 32'(out_valid), 32'(m_ov));
      if (m_ov)
         chk_res("cyc", {out_found, out_value, out_context, out_index, out_hits}, m_out);
   end

   task automatic scramble();
      selector    = 8'($urandom);
      bool_vec    = N'($urandom);
      value_bus   = {$urandom, $urandom};
      context_bus = {$urandom, $urandom};
      in_valid    = 1'($urandom_range(0, 1));
   endtask

   task automatic send(input logic [7:0] s, input logic [N-1:0] b,
                       input logic [N*DW-1:0] v, input logic [N*DW-1:0] c, input bit scr);
      int t = 0;
      @(negedge clk);
      selector = s; bool_vec = b; value_bus = v; context_bus = c; in_valid = 1'b1;
      while (!in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      if (scr) scramble();
      else in_valid = 1'b0;
   endtask

   task automatic collect(input int hold, input bit scr, output res_t r);
      int t = 0;
      while (!out_valid && t < N + 10) begin
         @(negedge clk);
         if (scr) scramble();
         t++;
      end
      chk("latency", 32'(t), 32'(N));
      r = {out_found, out_value, out_context, out_index, out_hits};
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         scramble();
         in_valid = 1'b1;
         chk("hold_in_ready", 32'(in_ready), 32'd0);
         chk_res("hold_stable", {out_found, out_value, out_context, out_index, out_hits}, r);
      end
      out_ready = 1'b1;
      in_valid  = 1'b0;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      res_t            r, e;
      logic [N*DW-1:0] v, c;
      logic [7:0]      s;
      logic [N-1:0]    b;

      repeat (3) @(negedge clk);
      chk_res("reset_out", {out_found, out_value, out_context, out_index, out_hits}, '0);
      chk("reset_valid", 32'(out_valid), 32'd0);
      chk("reset_ready_low", 32'(in_ready), 32'd0);
      reset = 1'b1;
      #1;
      chk("ready_after_reset", 32'(in_ready), 32'd1);

      // Lookup highest rank with a tie between cells 2 and 5.
      v = '0; c = '0;
      v[1*DW +: DW] = 8'd11; c[1*DW +: DW] = 8'd3;
      v[2*DW +: DW] = 8'd22; c[2*DW +: DW] = 8'd5;
      v[5*DW +: DW] = 8'd55; c[5*DW +: DW] = 8'd5;
      e = '{found: 1'b1, value: 8'd22, ctx: 8'd5, index: 8'd2, hits: 8'd3};
      chk_res("model_lookup", ref_reduce(8'd1, 8'b0010_0110, v, c), e);
      send(8'd1, 8'b0010_0110, v, c, 1'b1);
      collect(0, 1'b1, r);
      chk_res("lookup", r, e);

      // Mark-available: value is the cell handle, lowest index wins.
      for (int i = 0; i < N; i++) begin
         v[i*DW +: DW] = 8'(i);
         c[i*DW +: DW] = 8'(8'd100 + 8'(i));
      end
      e = '{found: 1'b1, value: 8'd4, ctx: 8'd104, index: 8'd4, hits: 8'd2};
      chk_res("model_mark", ref_reduce(8'd5, 8'b1001_0000, v, c), e);
      send(8'd5, 8'b1001_0000, v, c, 1'b0);
      collect(0, 1'b0, r);
      chk_res("mark", r, e);

      // No hit, with out_ready held low in DONE and new data offered.
      send(8'd2, 8'h00, v, c, 1'b0);
      collect(5, 1'b0, r);
      chk_res("nohit", r, '0);
      b = 8'b0100_0001;
      send(8'd0, b, v, c, 1'b0);
      collect(0, 1'b0, r);
      chk_res("after_bp", r, ref_reduce(8'd0, b, v, c));

      // Reset asserted so that scan edge E4 sees it.
      send(8'd1, 8'hFF, v, c, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_ready", 32'(in_ready), 32'd0);
      chk_res("rst_out", {out_found, out_value, out_context, out_index, out_hits}, '0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("rst_release_ready", 32'(in_ready), 32'd1);
      send(8'd1, 8'b1100_0000, v, c, 1'b1);
      collect(0, 1'b1, r);
      chk_res("post_rst", r, '{found: 1'b1, value: 8'd7, ctx: 8'd107, index: 8'd7, hits: 8'd2});

      // Randomized transactions with tie-prone contexts and backpressure.
      for (int n = 0; n < 150; n++) begin
         case ($urandom_range(0, 3))
            0:       s = 8'($urandom);
            1, 2:    s = 8'd1;
            default: s = 8'($urandom_range(0, 7));
         endcase
         case ($urandom_range(0, 5))
            0:       b = '0;
            1:       b = '1;
            default: b = N'($urandom);
         endcase
         for (int i = 0; i < N; i++) begin
            v[i*DW +: DW] = 8'($urandom);
            c[i*DW +: DW] = 8'($urandom_range(0, 3));
         end
         e = ref_reduce(s, b, v, c);
         send(s, b, v, c, 1'($urandom_range(0, 1)));
         collect($urandom_range(0, 3), 1'($urandom_range(0, 1)), r);
         chk_res("rand", r, e);
      end

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
